// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared requester ids, widths and read-tracking tag type
package mem_arbiter_pkg;
  localparam int ID_W = 2;
  localparam logic [ID_W-1:0] ID_CPU = 2'd0;
  localparam logic [ID_W-1:0] ID_ERX = 2'd1;
  localparam logic [ID_W-1:0] ID_ETX = 2'd2;
  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DATA_W = 16;
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } rd_tag_t;
  function automatic logic [ID_W-1:0] win_id(input logic [2:0] w);
    return w[1] ? ID_ERX : w[2] ? ID_ETX : ID_CPU;
  endfunction
endpackage

// File: rtl/mem_arbiter_rr_pick3.sv
// rr_pick3: combinational 3-way round-robin picker, search starts after ptr
module rr_pick3
  import mem_arbiter_pkg::*;
(
  input  logic [2:0]      elig,
  input  logic [ID_W-1:0] ptr,
  output logic [2:0]      win,
  output logic            valid
);
  logic [2:0] ord;
  logic [2:0] pick;
  // rotate the mask into priority order, take the first set bit, rotate back
  always_comb begin
    ord   = ptr == ID_CPU ? {elig[0], elig[2], elig[1]} :
            ptr == ID_ERX ? {elig[1], elig[0], elig[2]} : elig;
    pick  = ord[0] ? 3'b001 : ord[1] ? 3'b010 : ord[2] ? 3'b100 : 3'b000;
    win   = ptr == ID_CPU ? {pick[1], pick[0], pick[2]} :
            ptr == ID_ERX ? {pick[0], pick[2], pick[1]} : pick;
    valid = |elig;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of one memory port between cpu, erx and etx
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              erx_req,
  input  logic              erx_we,
  input  logic [ADDR_W-1:0] erx_addr,
  input  logic [DATA_W-1:0] erx_wdata,
  output logic              erx_gnt,
  output logic              erx_rvalid,
  output logic [DATA_W-1:0] erx_rdata,
  input  logic              etx_req,
  input  logic              etx_we,
  input  logic [ADDR_W-1:0] etx_addr,
  input  logic [DATA_W-1:0] etx_wdata,
  output logic              etx_gnt,
  output logic              etx_rvalid,
  output logic [DATA_W-1:0] etx_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  logic [2:0]        elig, win, gnt_d, gnt_q, rvalid_d, rvalid_q;
  logic              pick_valid, sel_we, en_d, en_q, we_d, we_q;
  logic [ID_W-1:0]   ptr_d, ptr_q;
  logic [ADDR_W-1:0] sel_addr, addr_d, addr_q;
  logic [DATA_W-1:0] sel_wdata, wdata_d, wdata_q;
  rd_tag_t           pipe_d [RD_LAT];
  rd_tag_t           pipe_q [RD_LAT];

  // a requester granted last cycle sits out this one so it can drop or renew its request
  assign elig = {etx_req & ~gnt_q[2], erx_req & ~gnt_q[1], cpu_req & ~gnt_q[0]};

  rr_pick3 u_pick (.elig(elig), .ptr(ptr_q), .win(win), .valid(pick_valid));

  // winner's access becomes the next memory command; idle cycles keep the old command fields
  always_comb begin
    sel_we    = win[2] ? etx_we    : win[1] ? erx_we    : cpu_we;
    sel_addr  = win[2] ? etx_addr  : win[1] ? erx_addr  : cpu_addr;
    sel_wdata = win[2] ? etx_wdata : win[1] ? erx_wdata : cpu_wdata;
    gnt_d     = win;
    en_d      = pick_valid;
    ptr_d     = pick_valid ? win_id(win) : ptr_q;
    we_d      = pick_valid ? sel_we    : we_q;
    addr_d    = pick_valid ? sel_addr  : addr_q;
    wdata_d   = pick_valid ? sel_wdata : wdata_q;
    pipe_d[0] = {pick_valid & ~sel_we, win_id(win)};
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
    rvalid_d  = pipe_q[RD_LAT-1].valid ? 3'b001 << pipe_q[RD_LAT-1].id : 3'b000;
  end

  // command, pointer and read-tracking registers; reset drops any in-flight read
  always_ff @(posedge CLK) begin
    if (reset) begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ptr_q    <= ID_ETX;
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ptr_q    <= ptr_d;
      pipe_q   <= pipe_d;
    end
  end

  assign {etx_gnt, erx_gnt, cpu_gnt}          = gnt_q;
  assign {etx_rvalid, erx_rvalid, cpu_rvalid} = rvalid_q;
  assign mem_en    = en_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = mem_rdata;
  assign erx_rdata = mem_rdata;
  assign etx_rdata = mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table plus corner sequences on RD_LAT=1 and RD_LAT=2 instances
module tb_mem_arbiter;
  logic CLK, reset, mon_en;
  logic [2:0] req, we;
  logic [2:0][14:0] addr;
  logic [2:0][15:0] wdata;
  logic [2:0] g1, v1, g2, v2;
  logic en1, we1, en2, we2;
  logic [14:0] ma1, ma2;
  logic [15:0] mw1, mw2, rdq1, rdq2, rdq2a;
  logic [2:0][15:0] rd1, rd2;
  logic [15:0] mem1 [logic [14:0]];
  logic [15:0] mem2 [logic [14:0]];
  int cyc = 0, errs = 0, total = 0;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] data;
    int          due;
  } rx_t;
  rx_t q1[$], q2[$];

  typedef struct {
    logic [2:0]       req, we;
    logic [2:0][14:0] addr;
    logic [2:0][15:0] wd;
    logic [2:0]       gnt;
    logic             xwe;
    logic [14:0]      xaddr;
    logic [15:0]      xwd, xrd;
  } vec_t;
  vec_t vt [12];

  mem_arbiter #(.ADDR_W(15), .DATA_W(16), .RD_LAT(1)) u1 (
    .CLK(CLK), .reset(reset),
    .cpu_req(req[0]), .cpu_we(we[0]), .cpu_addr(addr[0]), .cpu_wdata(wdata[0]),
    .cpu_gnt(g1[0]), .cpu_rvalid(v1[0]), .cpu_rdata(rd1[0]),
    .erx_req(req[1]), .erx_we(we[1]), .erx_addr(addr[1]), .erx_wdata(wdata[1]),
    .erx_gnt(g1[1]), .erx_rvalid(v1[1]), .erx_rdata(rd1[1]),
    .etx_req(req[2]), .etx_we(we[2]), .etx_addr(addr[2]), .etx_wdata(wdata[2]),
    .etx_gnt(g1[2]), .etx_rvalid(v1[2]), .etx_rdata(rd1[2]),
    .mem_en(en1), .mem_we(we1), .mem_addr(ma1), .mem_wdata(mw1), .mem_rdata(rdq1));

  mem_arbiter #(.ADDR_W(15), .DATA_W(16), .RD_LAT(2)) u2 (
    .CLK(CLK), .reset(reset),
    .cpu_req(req[0]), .cpu_we(we[0]), .cpu_addr(addr[0]), .cpu_wdata(wdata[0]),
    .cpu_gnt(g2[0]), .cpu_rvalid(v2[0]), .cpu_rdata(rd2[0]),
    .erx_req(req[1]), .erx_we(we[1]), .erx_addr(addr[1]), .erx_wdata(wdata[1]),
    .erx_gnt(g2[1]), .erx_rvalid(v2[1]), .erx_rdata(rd2[1]),
    .etx_req(req[2]), .etx_we(we[2]), .etx_addr(addr[2]), .etx_wdata(wdata[2]),
    .etx_gnt(g2[2]), .etx_rvalid(v2[2]), .etx_rdata(rd2[2]),
    .mem_en(en2), .mem_we(we2), .mem_addr(ma2), .mem_wdata(mw2), .mem_rdata(rdq2));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // memory models: unwritten words read as addr ^ 16'h5A5A
  always @(posedge CLK) begin
    if (en1 && we1) mem1[ma1] = mw1;
    if (en1 && !we1) rdq1 <= mem1.exists(ma1) ? mem1[ma1] : (16'(ma1) ^ 16'h5A5A);
    if (en2 && we2) mem2[ma2] = mw2;
    if (en2 && !we2) rdq2a <= mem2.exists(ma2) ? mem2[ma2] : (16'(ma2) ^ 16'h5A5A);
    rdq2 <= rdq2a;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [15:0] d);
    q1.push_back('{id, d, cyc + 2});
    q2.push_back('{id, d, cyc + 3});
  endtask

  task automatic mon(input int w, input logic [2:0] rv, input logic [2:0][15:0] rd);
    rx_t e;
    bit due = 0;
    if (w == 1 && q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); due = 1; end
    if (w == 2 && q2.size() > 0 && q2[0].due == cyc) begin e = q2.pop_front(); due = 1; end
    if (due) begin
      chk($sformatf("lat%0d_rvalid", w), 32'(rv), 32'(3'b001 << e.id));
      chk($sformatf("lat%0d_rdata", w), 32'(rd[e.id]), 32'(e.data));
    end else
      chk($sformatf("lat%0d_no_rvalid", w), 32'(rv), 32'd0);
  endtask

  always @(negedge CLK) if (mon_en) begin
    mon(1, v1, rd1);
    mon(2, v2, rd2);
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, 32'({g2, v2, en2, we2, g1, v1, en1, we1}), 32'd0);
    chk({nm, "_addr"}, 32'({ma2, ma1}), 32'd0);
    chk({nm, "_wdata"}, {mw2, mw1}, 32'd0);
  endtask

  initial begin
    vt[0]  = '{3'b001, 3'b000, {15'h0, 15'h0, 15'h12}, {16'h0, 16'h0, 16'h1111},
               3'b001, 1'b0, 15'h12, 16'h1111, 16'hBEEF};
    vt[1]  = '{3'b010, 3'b010, {15'h0, 15'h7FFF, 15'h0}, {16'h0, 16'h1234, 16'h0},
               3'b010, 1'b1, 15'h7FFF, 16'h1234, 16'h0};
    vt[2]  = '{3'b100, 3'b000, {15'h7FFF, 15'h0, 15'h0}, {16'h2222, 16'h0, 16'h0},
               3'b100, 1'b0, 15'h7FFF, 16'h2222, 16'h1234};
    vt[3]  = '{3'b111, 3'b000, {15'h3, 15'h2, 15'h1}, {16'h33, 16'h22, 16'h11},
               3'b001, 1'b0, 15'h1, 16'h11, 16'h5A5B};
    vt[4]  = '{3'b111, 3'b000, {15'h3, 15'h2, 15'h1}, {16'h33, 16'h22, 16'h11},
               3'b010, 1'b0, 15'h2, 16'h22, 16'h5A58};
    vt[5]  = '{3'b011, 3'b001, {15'h0, 15'h200, 15'h100}, {16'h0, 16'h44, 16'hCAFE},
               3'b001, 1'b1, 15'h100, 16'hCAFE, 16'h0};
    vt[6]  = '{3'b101, 3'b000, {15'h100, 15'h0, 15'h300}, {16'h55, 16'h0, 16'h66},
               3'b100, 1'b0, 15'h100, 16'h55, 16'hCAFE};
    vt[7]  = '{3'b110, 3'b000, {15'h500, 15'h4000, 15'h0}, {16'h88, 16'h7777, 16'h0},
               3'b010, 1'b0, 15'h4000, 16'h7777, 16'h1A5A};
    vt[8]  = '{3'b000, 3'b000, {15'h0, 15'h0, 15'h0}, {16'h0, 16'h0, 16'h0},
               3'b000, 1'b0, 15'h4000, 16'h7777, 16'h0};
    vt[9]  = '{3'b100, 3'b100, {15'h0, 15'h0, 15'h0}, {16'hFFFF, 16'h0, 16'h0},
               3'b100, 1'b1, 15'h0, 16'hFFFF, 16'h0};
    vt[10] = '{3'b001, 3'b000, {15'h0, 15'h0, 15'h0}, {16'h0, 16'h0, 16'h9},
               3'b001, 1'b0, 15'h0, 16'h9, 16'hFFFF};
    vt[11] = '{3'b111, 3'b111, {15'h6, 15'h5, 15'h4}, {16'hC, 16'hB, 16'hA},
               3'b010, 1'b1, 15'h5, 16'hB, 16'h0};
    mem1[15'h12] = 16'hBEEF;
    mem2[15'h12] = 16'hBEEF;
    mon_en = 1'b0;
    reset = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge CLK);
    chk_zero("reset");
    reset = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      req = vt[i].req; we = vt[i].we; addr = vt[i].addr; wdata = vt[i].wd;
      if (vt[i].gnt != 3'b000 && !vt[i].xwe)
        push(vt[i].gnt[1] ? 2'd1 : vt[i].gnt[2] ? 2'd2 : 2'd0, vt[i].xrd);
      @(negedge CLK);
      chk($sformatf("v%0d_gnt", i), 32'({g2, g1}), 32'({vt[i].gnt, vt[i].gnt}));
      chk($sformatf("v%0d_en_we", i), 32'({en2, en1, we2, we1}),
          32'({|vt[i].gnt, |vt[i].gnt, vt[i].xwe, vt[i].xwe}));
      chk($sformatf("v%0d_addr", i), 32'({ma2, ma1}), 32'({vt[i].xaddr, vt[i].xaddr}));
      chk($sformatf("v%0d_wdata", i), {mw2, mw1}, {vt[i].xwd, vt[i].xwd});
      req = '0;
      @(negedge CLK);
    end

    // three continuous readers from reset rotate cpu, erx, etx on consecutive cycles
    repeat (4) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    req = 3'b111; we = '0; addr = {15'h30, 15'h20, 15'h10};
    for (int k = 0; k < 6; k++) begin
      automatic int w = k % 3;
      automatic logic [2:0] oh = 3'b001 << w;
      push(2'(w), 16'(addr[w]) ^ 16'h5A5A);
      @(negedge CLK);
      chk($sformatf("rr%0d_gnt", k), 32'({g2, g1}), 32'({oh, oh}));
      chk($sformatf("rr%0d_en", k), 32'({en2, en1}), 32'b11);
      chk($sformatf("rr%0d_addr", k), 32'({ma2, ma1}), 32'({addr[w], addr[w]}));
    end
    req = '0;

    // a lone continuous requester is granted every other cycle
    repeat (4) @(negedge CLK);
    req = 3'b001; addr[0] = 15'h40;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) push(2'd0, 16'h5A1A);
      @(negedge CLK);
      chk($sformatf("solo%0d_gnt", k), 32'({g2, g1}), (k % 2 == 0) ? 32'b001001 : 32'd0);
    end
    req = '0;

    // reset in the grant cycle discards the read; cpu wins first afterwards
    repeat (4) @(negedge CLK);
    req = 3'b001; addr = {15'h30, 15'h20, 15'h12};
    @(negedge CLK);
    chk("mid_gnt", 32'({g2, g1}), 32'b001001);
    reset = 1'b1;
    req = 3'b111;
    @(negedge CLK);
    chk_zero("mid_reset");
    reset = 1'b0;
    push(2'd0, 16'hBEEF);
    @(negedge CLK);
    chk("post_reset_gnt", 32'({g2, g1}), 32'b001001);
    req = '0;
    repeat (6) @(negedge CLK);
    chk("lat1_drained", q1.size(), 0);
    chk("lat2_drained", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares the single-port packet/program memory between three requesters: the CPU data port, the Ethernet receive writer and the Ethernet transmit reader. It sits between those requesters and the memory array in the top-level design. It issues one word access per cycle and routes read data back to the requester that issued the read after the memory's fixed read latency.

## Interface
Parameters:
- ADDR_W, 15, memory word-address width
- DATA_W, 16, memory word width
- RD_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata (1..4)

Ports (XX is one of cpu, erx, etx; each requester has an identical port set):
- CLK  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- XX_req  in  1  access request, held until XX_gnt
- XX_we  in  1  1 = write, 0 = read; held with req
- XX_addr  in  ADDR_W  word address; held with req
- XX_wdata  in  DATA_W  write data; held with req
- XX_gnt  out  1  one-cycle pulse, access issued this cycle
- XX_rvalid  out  1  one-cycle pulse, XX_rdata valid
- XX_rdata  out  DATA_W  read data (mem_rdata broadcast to all three)
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_en

## Operation
- Cycle t: the arbiter evaluates eligible requests. At the t→t+1 edge it registers the winner's gnt, mem_en=1, mem_we, mem_addr and mem_wdata from that requester's inputs.
- Eligible means XX_req=1 and XX_gnt=0 in cycle t. The requester granted in cycle t cannot win at t+1. A single continuous requester is therefore granted at most every other cycle. Grants to different requesters may be back-to-back.
- Round-robin priority: a last-grant pointer selects the order. The order starts with the requester after the last grantee, in cyclic order cpu→erx→etx→cpu. The pointer updates only when a grant is issued.
- No eligible request: mem_en=0 and all gnt=0. mem_addr, mem_wdata and mem_we hold their previous values.
- Read tracking: each issued access pushes {valid = ~we, id} into an RD_LAT-deep shift register. When an entry with valid=1 exits, the arbiter pulses XX_rvalid for its id in the same cycle that mem_rdata is valid. Writes never produce rvalid.
- At most one rvalid is high per cycle. Read returns occur in issue order.
- Requesters must drop req or present a new access in the cycle after gnt. The arbiter does not check this; the gnt-cycle mask prevents a double grant.

## Timing
- Reset values: all gnt, rvalid, mem_en and mem_we are 0. mem_addr and mem_wdata are 0. The pointer is etx, so cpu has first priority. The read-tracking pipe is cleared.
- Grant latency: req sampled in cycle t gives gnt and mem_en in t+1. Best case is one cycle; worst case is three cycles with all requesters contending.
- Read latency: rvalid arrives in t+1+RD_LAT.
- Reset mid-operation: in-flight reads are discarded, and no rvalid is asserted after the reset cycle. Reset overrides any simultaneous request.
- All outputs except XX_rdata are registered. XX_rdata is combinational from mem_rdata.

## Structure
- Shared package: requester ID constants ID_CPU=0, ID_ERX=1, ID_ETX=2, the 2-bit ID width, and the default ADDR_W and DATA_W.
- One sub-module, rr_pick3: a combinational 3-way round-robin picker. Inputs are a 3-bit eligible mask and a 2-bit pointer. Outputs are a one-hot winner and a valid flag.
- The read-tracking shift register and the output registers stay in mem_arbiter.

## Test plan
- CPU read, alone: cpu_req at 0x0012 with we=0 in cycle t, memory model returns 0xBEEF, RD_LAT=1 → cpu_gnt, mem_en=1, mem_we=0 and mem_addr=0x0012 at t+1. cpu_rvalid=1 with cpu_rdata=0xBEEF at t+2. erx_rvalid and etx_rvalid stay 0.
- Three continuous requesters from reset → grant order cpu, erx, etx, cpu, erx, etx on consecutive cycles, mem_en held at 1.
- erx write of 0x1234 to 0x7FFF → mem_we=1, mem_addr=0x7FFF and mem_wdata=0x1234 one cycle after req. No rvalid on any port.
- cpu_req held high continuously, others idle → cpu_gnt pattern 1,0,1,0,…
- RD_LAT=2: cpu read issued at t+1, etx read issued at t+2 → cpu_rvalid at t+3 and etx_rvalid at t+4, each with the matching mem_rdata.
- Reset asserted the cycle after a cpu read grant → no cpu_rvalid. All outputs are 0 the next cycle. With all three requesting afterwards, the first grant goes to cpu.
